// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and constants for the VGA rectangle renderer
package vga_pkg;

  localparam int RGB_W          = 6;
  localparam int H_OFFSET_DEF   = 144;
  localparam int V_OFFSET_DEF   = 35;
  localparam int H_VISIBLE      = 640;
  localparam int V_VISIBLE      = 480;
  localparam int RENDER_LATENCY = 2;

  typedef logic [RGB_W-1:0] rgb222_t;

  typedef struct packed {
    logic       en;
    logic [9:0] x0;
    logic [9:0] x1;
    logic [9:0] y0;
    logic [9:0] y1;
    rgb222_t    color;
  } rect_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/vga_rect_renderer_if.sv
// rtl/vga_rect_renderer_if.sv - rectangle command port between host front end and renderer
interface vga_rect_renderer_if #(
  parameter int SLOT_W = 2
);
  import vga_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [SLOT_W-1:0] cmd_slot;
  logic              cmd_enable;
  logic [9:0]        cmd_x0;
  logic [9:0]        cmd_x1;
  logic [9:0]        cmd_y0;
  logic [9:0]        cmd_y1;
  rgb222_t           cmd_color;

  modport master (
    output cmd_valid, cmd_slot, cmd_enable, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_slot, cmd_enable, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output cmd_ready
  );

endinterface

// File: rtl/vga_rect_renderer_rect_hit.sv
// rtl/vga_rect_renderer_rect_hit.sv - combinational point-in-rectangle test for one slot
module rect_hit
  import vga_pkg::*;
(
  input  logic [9:0] px_i,
  input  logic [9:0] py_i,
  input  rect_t      rect_i,
  output logic       hit_o
);

  logic unused_color;
  assign unused_color = ^rect_i.color;

  // An inverted box (x0>x1 or y0>y1) fails both compares and so never hits.
  assign hit_o = rect_i.en
              && (px_i >= rect_i.x0) && (px_i <= rect_i.x1)
              && (py_i >= rect_i.y0) && (py_i <= rect_i.y1);

endmodule

// File: rtl/vga_rect_renderer.sv
// rtl/vga_rect_renderer.sv - two-stage rectangle overlay with vsync-committed double buffering
module vga_rect_renderer
  import vga_pkg::*;
#(
  parameter int NUM_RECTS = 4,
  parameter int H_OFFSET  = H_OFFSET_DEF,
  parameter int V_OFFSET  = V_OFFSET_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      hs_in,
  input  logic                      vs_in,
  input  logic [9:0]                x_in,
  input  logic [9:0]                y_in,
  input  logic                      active_in,
  input  rgb222_t                   bg_color,
  vga_rect_renderer_if.slave        cmd,
  output logic                      hs_out,
  output logic                      vs_out,
  output rgb222_t                   rgb,
  output logic [15:0]               frame_cnt
);

  logic [9:0]           px;
  logic [9:0]           py;
  rect_t                pending_q [NUM_RECTS];
  rect_t                shadow_q  [NUM_RECTS];
  logic [NUM_RECTS-1:0] dirty_q;
  logic [NUM_RECTS-1:0] hit;
  logic [NUM_RECTS-1:0] hit_q;
  logic                 act_q, hs1_q, vs1_q;
  logic                 hs2_q, vs2_q;
  rgb222_t              rgb_q, rgb_d;
  logic                 vs_prev_q, ready_q;
  logic                 commit, wr;
  commit_state_e        state_q, state_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;

  assign px = x_in - 10'(H_OFFSET);
  assign py = y_in - 10'(V_OFFSET);

  for (genvar i = 0; i < NUM_RECTS; i++) begin : g_hit
    rect_hit u_rect_hit (
      .px_i   (px),
      .py_i   (py),
      .rect_i (shadow_q[i]),
      .hit_o  (hit[i])
    );
  end

  // Commit cycle blocks writes so pending and shadow never update together.
  assign commit        = vs_prev_q && !vs_in;
  assign cmd.cmd_ready = ready_q && !commit;
  assign wr            = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      ST_IDLE:    if (wr)     state_d = ST_PENDING;
      ST_PENDING: if (commit) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
    if (commit) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RECTS; i++) begin
        pending_q[i] <= '0;
        shadow_q[i]  <= '0;
      end
      dirty_q     <= '0;
      vs_prev_q   <= 1'b1;
      ready_q     <= 1'b0;
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
    end else begin
      vs_prev_q   <= vs_in;
      ready_q     <= 1'b1;
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      if (commit) begin
        if (state_q == ST_PENDING) begin
          for (int i = 0; i < NUM_RECTS; i++) begin
            if (dirty_q[i]) shadow_q[i] <= pending_q[i];
          end
        end
        dirty_q <= '0;
      end else if (wr) begin
        pending_q[cmd.cmd_slot] <= '{en: cmd.cmd_enable, x0: cmd.cmd_x0, x1: cmd.cmd_x1,
                                     y0: cmd.cmd_y0, y1: cmd.cmd_y1, color: cmd.cmd_color};
        dirty_q[cmd.cmd_slot]   <= 1'b1;
      end
    end
  end

  // Lowest-index hit wins, so scan from the top and let lower slots overwrite.
  always_comb begin
    rgb_d = bg_color;
    for (int i = NUM_RECTS - 1; i >= 0; i--) begin
      if (hit_q[i]) rgb_d = shadow_q[i].color;
    end
    if (!act_q) rgb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q <= '0;
      act_q <= 1'b0;
      hs1_q <= 1'b1;
      vs1_q <= 1'b1;
      rgb_q <= '0;
      hs2_q <= 1'b1;
      vs2_q <= 1'b1;
    end else begin
      hit_q <= hit;
      act_q <= active_in;
      hs1_q <= hs_in;
      vs1_q <= vs_in;
      rgb_q <= rgb_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  assign rgb       = rgb_q;
  assign hs_out    = hs2_q;
  assign vs_out    = vs2_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_rect_renderer.sv
// tb/tb_vga_rect_renderer.sv - directed bench on a shrunken raster (32x10 visible, 184x48 total)
module tb_vga_rect_renderer;
  import vga_pkg::*;

  localparam int H_TOTAL = 184;
  localparam int V_TOTAL = 48;
  localparam int FRAME   = H_TOTAL * V_TOTAL;
  localparam int VIS_W   = 32;
  localparam int VIS_H   = 10;
  localparam rgb222_t BG = 6'b000011;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } drv_t;
  localparam drv_t IDLE_D = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  typedef struct packed {
    logic [1:0] slot;
    rect_t      r;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst_n, hs_in, vs_in, active_in, hs_out, vs_out;
  logic [9:0]  x_in, y_in;
  rgb222_t     bg_color, rgb;
  logic [15:0] frame_cnt;

  vga_rect_renderer_if #(.SLOT_W(2)) cmd_if ();

  vga_rect_renderer #(.NUM_RECTS(4), .H_OFFSET(144), .V_OFFSET(35)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hs_in     (hs_in),
    .vs_in     (vs_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .active_in (active_in),
    .bg_color  (bg_color),
    .cmd       (cmd_if),
    .hs_out    (hs_out),
    .vs_out    (vs_out),
    .rgb       (rgb),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  cmd_t        cmd_q [$];
  drv_t        h0, h1;
  int          gx, gy;
  logic        rst_drive, mon_en, accepted, drv_ready;
  int          hist [64];
  int          blank_bad, sync_bad;
  int          n_vec, n_err;
  logic        s_hs, s_vs, s_ready;
  rgb222_t     s_rgb;
  logic [15:0] s_fc;

  task automatic check_vec(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel clock: sample outputs, then drive the next raster position and command.
  task automatic tick();
    drv_t d;
    @(negedge clk);
    s_rgb   = rgb;
    s_hs    = hs_out;
    s_vs    = vs_out;
    s_fc    = frame_cnt;
    s_ready = cmd_if.cmd_ready;
    if (mon_en) begin
      if (s_hs !== h1.hs || s_vs !== h1.vs) sync_bad++;
      if (h1.act) hist[s_rgb]++;
      else if (s_rgb !== 6'd0) blank_bad++;
    end
    if (accepted) void'(cmd_q.pop_front());
    d.hs  = !(gx < 8);
    d.vs  = !(gy < 2);
    d.act = (gx >= 144) && (gx < 144 + VIS_W) && (gy >= 35) && (gy < 35 + VIS_H);
    x_in      = 10'(gx);
    y_in      = 10'(gy);
    hs_in     = d.hs;
    vs_in     = d.vs;
    active_in = d.act;
    rst_n     = rst_drive;
    if (cmd_q.size() > 0) begin
      cmd_if.cmd_valid  = 1'b1;
      cmd_if.cmd_slot   = cmd_q[0].slot;
      cmd_if.cmd_enable = cmd_q[0].r.en;
      cmd_if.cmd_x0     = cmd_q[0].r.x0;
      cmd_if.cmd_x1     = cmd_q[0].r.x1;
      cmd_if.cmd_y0     = cmd_q[0].r.y0;
      cmd_if.cmd_y1     = cmd_q[0].r.y1;
      cmd_if.cmd_color  = cmd_q[0].r.color;
    end else begin
      cmd_if.cmd_valid = 1'b0;
    end
    h1 = h0;
    h0 = d;
    if (!rst_drive) begin
      h0 = IDLE_D;
      h1 = IDLE_D;
    end
    gx++;
    if (gx == H_TOTAL) begin
      gx = 0;
      gy++;
      if (gy == V_TOTAL) gy = 0;
    end
    #1;
    drv_ready = cmd_if.cmd_ready;
    accepted  = cmd_if.cmd_valid && drv_ready && rst_drive;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input int slot, input int x0, input int x1, input int y0, input int y1,
                      input rgb222_t color);
    cmd_t c;
    c.slot    = 2'(slot);
    c.r.en    = 1'b1;
    c.r.x0    = 10'(x0);
    c.r.x1    = 10'(x1);
    c.r.y0    = 10'(y0);
    c.r.y1    = 10'(y1);
    c.r.color = color;
    cmd_q.push_back(c);
  endtask

  task automatic frame_begin();
    for (int i = 0; i < 64; i++) hist[i] = 0;
  endtask

  task automatic frame_end(input string f, input int fc_exp);
    check_vec({f, "_frame_cnt"}, int'(s_fc), fc_exp);
    check_vec({f, "_sync_delay_errs"}, sync_bad, 0);
    check_vec({f, "_blank_nonzero"}, blank_bad, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; blank_bad = 0; sync_bad = 0;
    mon_en = 1'b0; accepted = 1'b0; drv_ready = 1'b0;
    h0 = IDLE_D; h1 = IDLE_D;
    bg_color = BG;
    rst_n = 1'b0; hs_in = 1'b1; vs_in = 1'b1; active_in = 1'b0; x_in = '0; y_in = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_slot = '0; cmd_if.cmd_enable = 1'b0;
    cmd_if.cmd_x0 = '0; cmd_if.cmd_x1 = '0; cmd_if.cmd_y0 = '0; cmd_if.cmd_y1 = '0;
    cmd_if.cmd_color = '0;
    frame_begin();

    // Reset over the last raster positions so frame 1 starts at (0,0).
    gx = H_TOTAL - 3; gy = V_TOTAL - 1; rst_drive = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    rst_drive = 1'b1;
    tick();
    check_vec("rst_rgb", int'(s_rgb), 0);
    check_vec("rst_hs_out", int'(s_hs), 1);
    check_vec("rst_vs_out", int'(s_vs), 1);
    check_vec("rst_frame_cnt", int'(s_fc), 0);
    check_vec("rst_cmd_ready", int'(s_ready), 0);

    // F1: background only; slot0 written mid-scan must not touch this frame.
    frame_begin();
    run(38 * H_TOTAL);
    push(0, 10, 19, 5, 7, 6'b110000);
    run(FRAME - 38 * H_TOTAL);
    check_vec("f1_bg_pixels", hist[BG], 320);
    frame_end("f1", 1);

    // F2: slot0 box visible; queue full-screen slot1 for the next frame.
    frame_begin();
    run(20 * H_TOTAL);
    push(1, 0, 639, 0, 479, 6'b001100);
    run(FRAME - 20 * H_TOTAL);
    check_vec("f2_slot0_pixels", hist[6'b110000], 30);
    check_vec("f2_bg_pixels", hist[BG], 290);
    frame_end("f2", 2);

    // F3: overlap, slot0 on top of slot1.
    frame_begin();
    run(FRAME);
    check_vec("f3_slot0_pixels", hist[6'b110000], 30);
    check_vec("f3_slot1_pixels", hist[6'b001100], 290);
    check_vec("f3_bg_pixels", hist[BG], 0);
    check_vec("f3_ready_before_vsync", int'(drv_ready), 1);
    frame_end("f3", 3);

    // F4: command held across the vsync edge, then double write and inverted rect.
    push(3, 0, 3, 0, 0, 6'b000001);
    frame_begin();
    run(1);
    check_vec("ready_in_commit_cycle", int'(drv_ready), 0);
    check_vec("accept_in_commit_cycle", int'(accepted), 0);
    run(1);
    check_vec("ready_after_commit", int'(drv_ready), 1);
    check_vec("accept_after_commit", int'(accepted), 1);
    run(30 * H_TOTAL - 2);
    push(2, 20, 29, 8, 9, 6'b010101);
    push(2, 20, 29, 8, 9, 6'b101010);
    push(1, 20, 10, 0, 9, 6'b111111);
    run(FRAME - 30 * H_TOTAL);
    check_vec("f4_slot0_pixels", hist[6'b110000], 30);
    check_vec("f4_slot1_pixels", hist[6'b001100], 290);
    check_vec("f4_late_write_hidden", hist[6'b000001], 0);
    frame_end("f4", 4);

    // F5: last write wins, inverted slot never draws.
    frame_begin();
    run(FRAME);
    check_vec("f5_slot0_pixels", hist[6'b110000], 30);
    check_vec("f5_slot2_b_pixels", hist[6'b101010], 20);
    check_vec("f5_slot2_a_pixels", hist[6'b010101], 0);
    check_vec("f5_slot3_pixels", hist[6'b000001], 4);
    check_vec("f5_inverted_pixels", hist[6'b111111], 0);
    check_vec("f5_old_slot1_pixels", hist[6'b001100], 0);
    check_vec("f5_bg_pixels", hist[BG], 266);
    frame_end("f5", 5);

    // F6: one-cycle reset in the middle of a visible line.
    frame_begin();
    run(38 * H_TOTAL + 150);
    rst_drive = 1'b0;
    run(1);
    rst_drive = 1'b1;
    run(1);
    check_vec("midrst_rgb", int'(s_rgb), 0);
    check_vec("midrst_hs_out", int'(s_hs), 1);
    check_vec("midrst_vs_out", int'(s_vs), 1);
    check_vec("midrst_frame_cnt", int'(s_fc), 0);
    check_vec("midrst_cmd_ready", int'(s_ready), 0);
    run(1);
    check_vec("postrst_rgb", int'(s_rgb), 0);
    check_vec("postrst_cmd_ready", int'(s_ready), 1);
    run(FRAME - (38 * H_TOTAL + 150) - 3);
    check_vec("f6_slot0_after_rst", hist[6'b110000], 0);
    frame_end("f6", 0);

    // F7: everything cleared by reset.
    frame_begin();
    run(FRAME);
    check_vec("f7_bg_pixels", hist[BG], 320);
    check_vec("f7_slot0_pixels", hist[6'b110000], 0);
    frame_end("f7", 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
